sdram_responder: RTL and testbench

//   Cycle-accurate SDRAM device responder for bench and on-board loopback.

---
 rtl/sdram_responder.sv | 178 +++++++++++++++++
 tb/tb_sdram_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// SDRAM device responder: decodes controller commands, enforces init order and
// command spacing, tracks open banks and serves single-rate bursts of two words.
module sdram_responder #(
  parameter int unsigned T_RP     = 3,
  parameter int unsigned T_MRD    = 2,
  parameter int unsigned T_RFC    = 11,
  parameter int unsigned T_RCD    = 3,
  parameter int unsigned COL_BITS = 4
) (
  input  logic        clk133_p,
  input  logic        rst,
  input  logic        sd_CKE,
  input  logic        sd_CS,
  input  logic        sd_RAS,
  input  logic        sd_CAS,
  input  logic        sd_WE,
  input  logic [1:0]  sd_BA,
  input  logic [12:0] sd_A,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        initDone,
  output logic        errorFlag,
  output logic [2:0]  errorCode
);

  localparam int unsigned ADDR_W = COL_BITS + 2;
  localparam int unsigned DEPTH  = 4 * (2 ** COL_BITS);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BUSY_W = 3;

  typedef enum logic [2:0] {
    C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
    C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111
  } cmd_t;

  // Each init state names the command it is waiting for.
  typedef enum logic [3:0] {
    S_WAIT_CKE, S_PRE0, S_EMR, S_MR0, S_PRE1, S_AR0, S_AR1, S_MR1, S_READY
  } init_t;

  init_t              st;
  init_t              st_eff;
  cmd_t               cmd;
  logic               cmd_v;
  logic               init_ok;
  logic               ready;
  logic               mode_ld;
  logic               mode_ok;
  logic               rw;
  logic               bank_err;
  logic               go;
  logic [2:0]         err_c;
  logic [CNT_W-1:0]   t_cnt;
  logic [2:0]         t_code;
  logic [BUSY_W-1:0]  busy;
  logic [3:0]         bank_open;
  logic [2:0]         cl;
  logic               wr1;
  logic               wr2;
  logic [ADDR_W-1:0]  wr_addr;
  logic [2:0]         rd_cnt;
  logic               rd2;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [15:0]        mem [DEPTH];
  logic               unused_addr;

  assign unused_addr = ^{sd_A[12:11], sd_A[9:7]};

  // Command decode, init-order check and first-error selection.
  always_comb begin
    cmd      = cmd_t'({sd_RAS, sd_CAS, sd_WE});
    cmd_v    = sd_CKE && !sd_CS && (cmd != C_NOP) && (cmd != C_BST);
    st_eff   = (st == S_WAIT_CKE && sd_CKE) ? S_PRE0 : st;
    cmd_addr = {sd_BA, sd_A[COL_BITS-1:0]};
    init_ok  = 1'b1;
    case (st_eff)
      S_PRE0, S_PRE1: init_ok = (cmd == C_PRE) && sd_A[10];
      S_EMR:          init_ok = (cmd == C_LMR) && (sd_BA == 2'b01);
      S_MR0, S_MR1:   init_ok = (cmd == C_LMR) && (sd_BA == 2'b00);
      S_AR0, S_AR1:   init_ok = (cmd == C_REF);
      default:        init_ok = 1'b1;
    endcase
    ready    = (st == S_READY);
    mode_ld  = cmd_v && (cmd == C_LMR) && (sd_BA == 2'b00);
    mode_ok  = ((sd_A[6:4] == 3'b010) || (sd_A[6:4] == 3'b011)) && (sd_A[2:0] == 3'b001);
    rw       = cmd_v && ready && ((cmd == C_RD) || (cmd == C_WR));
    bank_err = (cmd_v && (busy != '0)) || (rw && !bank_open[sd_BA]);
    go       = rw && !bank_err;
    err_c    = 3'd0;
    if (cmd_v && !init_ok)         err_c = 3'd1;
    else if (cmd_v && t_cnt != '0) err_c = t_code;
    else if (mode_ld && !mode_ok)  err_c = 3'd7;
    else if (bank_err)             err_c = 3'd6;
  end

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      st        <= S_WAIT_CKE;
      initDone  <= 1'b0;
      errorFlag <= 1'b0;
      errorCode <= 3'd0;
      t_cnt     <= '0;
      t_code    <= 3'd0;
      busy      <= '0;
      bank_open <= 4'b0000;
      cl        <= 3'd2;
      wr1       <= 1'b0;
      wr2       <= 1'b0;
      wr_addr   <= '0;
      rd_cnt    <= 3'd0;
      rd2       <= 1'b0;
      rd_addr   <= '0;
      dq_oe     <= 1'b0;
      dq_out    <= 16'h0000;
    end else begin
      if (st == S_WAIT_CKE && sd_CKE) st <= S_PRE0;
      if (cmd_v && st_eff != S_READY && init_ok) begin
        st <= init_t'(4'(st_eff) + 4'd1);
        if (st_eff == S_MR1) initDone <= 1'b1;
      end

      if (!errorFlag && err_c != 3'd0) begin
        errorFlag <= 1'b1;
        errorCode <= err_c;
      end

      // Spacing counter reaches zero exactly t* cycles after the command.
      if (cmd_v) begin
        case (cmd)
          C_PRE:   begin t_cnt <= CNT_W'(T_RP - 1);  t_code <= 3'd2; end
          C_LMR:   begin t_cnt <= CNT_W'(T_MRD - 1); t_code <= 3'd3; end
          C_REF:   begin t_cnt <= CNT_W'(T_RFC - 1); t_code <= 3'd4; end
          C_ACT:   begin t_cnt <= CNT_W'(T_RCD - 1); t_code <= 3'd5; end
          default: t_cnt <= '0;
        endcase
      end else if (t_cnt != '0) begin
        t_cnt <= t_cnt - CNT_W'(1);
      end

      if (mode_ld && mode_ok) cl <= sd_A[6:4];

      if (cmd_v && ready) begin
        if (cmd == C_ACT) bank_open[sd_BA] <= 1'b1;
        if (cmd == C_PRE) begin
          if (sd_A[10]) bank_open <= 4'b0000;
          else          bank_open[sd_BA] <= 1'b0;
        end
      end

      if (go) busy <= (cmd == C_RD) ? BUSY_W'(cl) + BUSY_W'(1) : BUSY_W'(2);
      else if (busy != '0) busy <= busy - BUSY_W'(1);

      wr2 <= wr1;
      wr1 <= go && (cmd == C_WR);
      if (go && cmd == C_WR) wr_addr <= cmd_addr;

      // rd_cnt hits 1 on the CL-th edge after the RD command.
      if (go && cmd == C_RD) begin
        rd_cnt  <= cl;
        rd_addr <= cmd_addr;
      end else if (rd_cnt != 3'd0) begin
        rd_cnt <= rd_cnt - 3'd1;
      end
      rd2   <= (rd_cnt == 3'd1);
      dq_oe <= (rd_cnt == 3'd1) || rd2;
      if (rd_cnt == 3'd1) dq_out <= mem[rd_addr];
      else if (rd2)       dq_out <= mem[rd_addr ^ ADDR_W'(1)];
    end
  end

  always_ff @(posedge clk133_p) begin
    if (wr1) mem[wr_addr] <= dq_in;
    if (wr2) mem[wr_addr ^ ADDR_W'(1)] <= dq_in;
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, bursts, timing/mode/bank errors, reset.
module tb_sdram_responder;

  logic        clk133_p = 1'b0;
  logic        rst = 1'b1;
  logic        sd_CKE = 1'b0;
  logic        sd_CS = 1'b1;
  logic        sd_RAS = 1'b1;
  logic        sd_CAS = 1'b1;
  logic        sd_WE = 1'b1;
  logic [1:0]  sd_BA = 2'b00;
  logic [12:0] sd_A = 13'h0000;
  logic [15:0] dq_in = 16'h0000;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        initDone;
  logic        errorFlag;
  logic [2:0]  errorCode;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [2:0] LMR = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011,
                         WR = 3'b100, RD = 3'b101;

  sdram_responder dut (
    .clk133_p (clk133_p),
    .rst      (rst),
    .sd_CKE   (sd_CKE),
    .sd_CS    (sd_CS),
    .sd_RAS   (sd_RAS),
    .sd_CAS   (sd_CAS),
    .sd_WE    (sd_WE),
    .sd_BA    (sd_BA),
    .sd_A     (sd_A),
    .dq_in    (dq_in),
    .dq_out   (dq_out),
    .dq_oe    (dq_oe),
    .initDone (initDone),
    .errorFlag(errorFlag),
    .errorCode(errorCode)
  );

  always #5 clk133_p = ~clk133_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command for one clock, then back to NOP; returns #1 after the edge.
  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a);
    sd_CS = 1'b0;
    {sd_RAS, sd_CAS, sd_WE} = c;
    sd_BA = ba;
    sd_A  = a;
    @(posedge clk133_p);
    #1;
    sd_CS = 1'b1;
    {sd_RAS, sd_CAS, sd_WE} = 3'b111;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk133_p);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sd_CKE = 1'b0;
    idle(2);
    rst = 1'b0;
    sd_CKE = 1'b1;
    idle(1);
  endtask

  // Legal init sequence at minimum spacing.
  task automatic do_init(input logic [12:0] mode);
    issue(PRE, 2'b00, 13'h0400);
    idle(2);
    issue(LMR, 2'b01, 13'h0000);
    idle(1);
    issue(LMR, 2'b00, mode);
    idle(1);
    issue(PRE, 2'b00, 13'h0400);
    idle(2);
    issue(REF, 2'b00, 13'h0000);
    idle(10);
    issue(REF, 2'b00, 13'h0000);
    idle(10);
    chk("init_done_before_mr1", 32'(initDone), 32'd0);
    issue(LMR, 2'b00, mode);
  endtask

  initial begin
    // Reset values
    idle(1);
    #1;
    chk("rst_init_done", 32'(initDone), 32'd0);
    chk("rst_error_flag", 32'(errorFlag), 32'd0);
    chk("rst_error_code", 32'(errorCode), 32'd0);
    chk("rst_dq_oe", 32'(dq_oe), 32'd0);
    chk("rst_dq_out", 32'(dq_out), 32'h0);
    do_reset();

    // 1: legal init
    do_init(13'h0021);
    chk("t1_init_done", 32'(initDone), 32'd1);
    chk("t1_error_flag", 32'(errorFlag), 32'd0);

    // 2: write then read, CL2
    idle(1);
    issue(ACT, 2'b00, 13'h0000);
    idle(2);
    issue(WR, 2'b00, 13'h0004);
    dq_in = 16'h5555;
    idle(1);
    dq_in = 16'hAAAA;
    idle(1);
    issue(RD, 2'b00, 13'h0004);
    chk("t2_oe_rd0", 32'(dq_oe), 32'd0);
    idle(1);
    chk("t2_oe_rd1", 32'(dq_oe), 32'd0);
    idle(1);
    chk("t2_oe_rd2", 32'(dq_oe), 32'd1);
    chk("t2_data0", 32'(dq_out), 32'h5555);
    idle(1);
    chk("t2_oe_rd3", 32'(dq_oe), 32'd1);
    chk("t2_data1", 32'(dq_out), 32'hAAAA);
    idle(1);
    chk("t2_oe_rd4", 32'(dq_oe), 32'd0);
    chk("t2_error_flag", 32'(errorFlag), 32'd0);

    // 3: tRFC violation latched, later tRP violation ignored
    issue(REF, 2'b00, 13'h0000);
    idle(9);
    chk("t3_no_err_yet", 32'(errorFlag), 32'd0);
    issue(PRE, 2'b00, 13'h0400);
    chk("t3_error_flag", 32'(errorFlag), 32'd1);
    chk("t3_error_code", 32'(errorCode), 32'd4);
    issue(PRE, 2'b00, 13'h0400);
    chk("t3_code_held", 32'(errorCode), 32'd4);

    // 4: read to closed bank
    do_reset();
    chk("t4_reset_flag", 32'(errorFlag), 32'd0);
    do_init(13'h0021);
    idle(1);
    issue(RD, 2'b10, 13'h0000);
    chk("t4_error_flag", 32'(errorFlag), 32'd1);
    chk("t4_error_code", 32'(errorCode), 32'd6);
    idle(2);
    chk("t4_oe_rd2", 32'(dq_oe), 32'd0);
    idle(1);
    chk("t4_oe_rd3", 32'(dq_oe), 32'd0);

    // 5: CL3 read, then illegal mode
    do_reset();
    do_init(13'h0021);
    idle(1);
    issue(LMR, 2'b00, 13'h0031);
    chk("t5_cl3_accepted", 32'(errorFlag), 32'd0);
    idle(1);
    issue(ACT, 2'b01, 13'h0123);
    idle(2);
    issue(WR, 2'b01, 13'h0005);
    dq_in = 16'h1234;
    idle(1);
    dq_in = 16'hBEEF;
    idle(1);
    issue(RD, 2'b01, 13'h0005);
    idle(2);
    chk("t5_oe_rd2", 32'(dq_oe), 32'd0);
    idle(1);
    chk("t5_oe_rd3", 32'(dq_oe), 32'd1);
    chk("t5_data0", 32'(dq_out), 32'h1234);
    idle(1);
    chk("t5_oe_rd4", 32'(dq_oe), 32'd1);
    chk("t5_data1", 32'(dq_out), 32'hBEEF);
    idle(1);
    chk("t5_oe_rd5", 32'(dq_oe), 32'd0);
    chk("t5_no_err", 32'(errorFlag), 32'd0);
    issue(LMR, 2'b00, 13'h0022);
    chk("t5_error_flag", 32'(errorFlag), 32'd1);
    chk("t5_error_code", 32'(errorCode), 32'd7);

    // 6: reset during a burst, then out-of-order init command
    do_reset();
    do_init(13'h0021);
    idle(1);
    issue(ACT, 2'b00, 13'h0000);
    idle(2);
    issue(WR, 2'b00, 13'h0002);
    dq_in = 16'h1111;
    idle(1);
    dq_in = 16'h2222;
    idle(1);
    issue(RD, 2'b00, 13'h0002);
    idle(2);
    chk("t6_burst_on", 32'(dq_oe), 32'd1);
    chk("t6_burst_data", 32'(dq_out), 32'h1111);
    rst = 1'b1;
    sd_CKE = 1'b0;
    #1;
    chk("t6_async_oe", 32'(dq_oe), 32'd0);
    chk("t6_async_init", 32'(initDone), 32'd0);
    chk("t6_async_out", 32'(dq_out), 32'h0);
    idle(2);
    rst = 1'b0;
    idle(1);
    issue(REF, 2'b00, 13'h0000);
    chk("t6_cke_low_ignored", 32'(errorFlag), 32'd0);
    chk("t6_no_oe", 32'(dq_oe), 32'd0);
    sd_CKE = 1'b1;
    issue(REF, 2'b00, 13'h0000);
    chk("t6_error_flag", 32'(errorFlag), 32'd1);
    chk("t6_error_code", 32'(errorCode), 32'd1);
    chk("t6_init_done", 32'(initDone), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
